apb_irq_ctrl: RTL

Parametrised APB interrupt controller that aggregates up to 32 peripheral interrupt sources into one registered interrupt line. It provides per-source edge/level mode, sticky edge capture with write-1-to-clear, a software trigger and an input synchroniser. It sits between the I2C master core flag outputs (or any peripheral status bus) and the system interrupt input. It replaces fixed-width, level-only RIS/IM/MIS logic with a reusable block that adds a one-wait-state APB slave and error signalling.

---
 rtl/apb_irq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: per-source synchroniser/edge-capture lanes feeding a
// RIS/IM/MIS/ICR/EDGE/SWI register block behind a one-wait-state APB slave.

module apb_irq_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  input  logic set,
  output logic ris
);
  logic s, p, ev;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign s = sync_q[SYNC_STAGES-1];
  end

  assign ev = s & ~p;

  // Edge mode is sticky; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      p   <= 1'b0;
      ris <= 1'b0;
    end else begin
      p <= s;
      if (!edge_mode)    ris <= s;
      else if (ev | set) ris <= 1'b1;
      else if (clr)      ris <= 1'b0;
    end
  end
endmodule

module apb_irq_ctrl #(
  parameter int          NUM_IRQ     = 9,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] BASE        = 16'h0F00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [15:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} apb_st_t;

  apb_st_t            state, state_nxt;
  logic [NUM_IRQ-1:0] ris, mis, im_q, edge_q, wdata, icr_stb, swi_stb;
  logic [4:0]         off;
  logic               blk_hit, map_hit, acc_err;
  logic               sel_ris, sel_im, sel_mis, sel_icr, sel_edge, sel_swi;
  logic               start, wr_en;
  logic [31:0]        rdata;
  logic               unused_pwdata;

  assign wdata         = PWDATA[NUM_IRQ-1:0];
  assign unused_pwdata = &{1'b0, PWDATA};

  // Address decode: block match ignores the low 5 bits of BASE.
  assign blk_hit  = (PADDR[15:5] == BASE[15:5]);
  assign off      = PADDR[4:0];
  assign sel_ris  = blk_hit & (off == 5'h04);
  assign sel_im   = blk_hit & (off == 5'h08);
  assign sel_mis  = blk_hit & (off == 5'h0C);
  assign sel_icr  = blk_hit & (off == 5'h10);
  assign sel_edge = blk_hit & (off == 5'h14);
  assign sel_swi  = blk_hit & (off == 5'h18);
  assign map_hit  = sel_ris | sel_im | sel_mis | sel_icr | sel_edge | sel_swi;
  assign acc_err  = ~map_hit | (PWRITE & (sel_ris | sel_mis));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (PSEL & PENABLE & ~PREADY) state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = PSEL ? ST_DONE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start = 1'b0;
    wr_en = 1'b0;
    case (state)
      ST_IDLE: start = PSEL & PENABLE & ~PREADY;
      ST_WAIT: wr_en = PSEL & PENABLE & PWRITE & PREADY & ~PSLVERR;
      default: ;
    endcase
  end

  // PREADY/PSLVERR are loaded on entry to WAIT, so they cover exactly the second access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= start;
      PSLVERR <= start & acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_q   <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en & sel_im)   im_q   <= wdata;
      if (wr_en & sel_edge) edge_q <= wdata;
      irq <= |mis;
    end
  end

  assign icr_stb = {NUM_IRQ{wr_en & sel_icr}} & wdata;
  assign swi_stb = {NUM_IRQ{wr_en & sel_swi}} & wdata;
  assign mis     = ris & im_q;

  apb_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane [NUM_IRQ-1:0] (
    .clk       (clk),
    .rst       (rst),
    .src       (irq_src),
    .edge_mode (edge_q),
    .clr       (icr_stb),
    .set       (swi_stb),
    .ris       (ris)
  );

  always_comb begin
    rdata = 32'hDEADBEEF;
    if (map_hit) begin
      rdata = '0;
      if (sel_ris)  rdata = 32'(ris);
      if (sel_im)   rdata = 32'(im_q);
      if (sel_mis)  rdata = 32'(mis);
      if (sel_edge) rdata = 32'(edge_q);
    end
  end

  assign PRDATA = PREADY ? rdata : 32'h0;
endmodule
